// File: rtl/fbu_pkg.sv
// Shared definitions for the FBCPU program memory and loader.
// Build option FBU_LOAD_CHECKSUM_EN adds a trailer checksum byte to each load.
package fbu_pkg;

    localparam int unsigned FBU_ADDRESS_WIDTH = 6;
    localparam int unsigned FBU_DATA_WIDTH    = 10;

    localparam int unsigned LD_STATE_W = 3;

    typedef enum logic [LD_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LO    = 3'd2,
        ST_HI    = 3'd3,
        ST_CSUM  = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERR   = 3'd6
    } ld_state_e;

    typedef struct packed {
        logic cpu_rst;
        logic busy;
        logic done;
        logic in_ready;
    } ld_flags_t;

    // FBCPU opcodes
    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_JZ    = 4'd7;
    localparam logic [3:0] OP_NOP   = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd9;

    // Status outputs are a pure function of the loader state.
    function automatic ld_flags_t flags_of(input ld_state_e s);
        ld_flags_t f;
        f.cpu_rst  = (s != ST_RUN);
        f.busy     = (s == ST_COUNT) || (s == ST_LO) || (s == ST_HI) || (s == ST_CSUM);
        f.done     = (s == ST_RUN);
        f.in_ready = f.busy;
        return f;
    endfunction

endpackage

// File: rtl/fbu_sp_ram.sv
// Single-port RAM: synchronous read-first read with synchronous clear, synchronous write.
module fbu_sp_ram #(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic                     we,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= clr ? '0 : mem[addr];
    end

endmodule

// File: rtl/fbu_prog_mem.sv
// FBCPU program/data memory with a byte-serial loader that holds the CPU in reset until loaded.
// Build option FBU_LOAD_CHECKSUM_EN enables the CSUM/ERR trailer check and load_err.
module fbu_prog_mem
    import fbu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = FBU_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = FBU_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
    input  logic                     cpu_wr,
    input  logic [DATA_WIDTH-1:0]    cpu_mdr_in,
    output logic [DATA_WIDTH-1:0]    cpu_mdr_out,
    output logic                     cpu_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     load_err
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
    localparam int unsigned CW    = ADDRESS_WIDTH + 1;

    ld_state_e                state;
    ld_flags_t                flg;
    logic [ADDRESS_WIDTH-1:0] ld_addr;
    logic [CW-1:0]            rem;
    logic [7:0]               lo;
    logic                     accept;

    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic                     ram_we;
    logic [DATA_WIDTH-1:0]    ram_wdata;
    logic                     ram_clr;

    // Count byte of 0 or anything above the depth means a full memory image.
    function automatic logic [CW-1:0] word_count(input logic [7:0] b);
        if (b == 8'd0 || 32'(b) > DEPTH) begin
            return CW'(DEPTH);
        end
        return CW'(b);
    endfunction

    assign accept = in_valid && flg.in_ready;

`ifdef FBU_LOAD_CHECKSUM_EN
    logic [7:0] sum;
    logic       err_q;
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            flg     <= flags_of(ST_IDLE);
            ld_addr <= '0;
            rem     <= '0;
            lo      <= '0;
`ifdef FBU_LOAD_CHECKSUM_EN
            sum     <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (load_start) begin
                        state   <= ST_COUNT;
                        flg     <= flags_of(ST_COUNT);
                        ld_addr <= '0;
                        rem     <= '0;
`ifdef FBU_LOAD_CHECKSUM_EN
                        sum     <= '0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                ST_COUNT: begin
                    if (accept) begin
                        rem   <= word_count(in_data);
                        state <= ST_LO;
                        flg   <= flags_of(ST_LO);
`ifdef FBU_LOAD_CHECKSUM_EN
                        sum   <= in_data;
`endif
                    end
                end
                ST_LO: begin
                    if (accept) begin
                        lo    <= in_data;
                        state <= ST_HI;
                        flg   <= flags_of(ST_HI);
`ifdef FBU_LOAD_CHECKSUM_EN
                        sum   <= 8'(sum + in_data);
`endif
                    end
                end
                ST_HI: begin
                    if (accept) begin
                        ld_addr <= ld_addr + ADDRESS_WIDTH'(1);
                        rem     <= rem - CW'(1);
`ifdef FBU_LOAD_CHECKSUM_EN
                        sum     <= 8'(sum + in_data);
`endif
                        if (rem == CW'(1)) begin
`ifdef FBU_LOAD_CHECKSUM_EN
                            state <= ST_CSUM;
                            flg   <= flags_of(ST_CSUM);
`else
                            state <= ST_RUN;
                            flg   <= flags_of(ST_RUN);
`endif
                        end else begin
                            state <= ST_LO;
                            flg   <= flags_of(ST_LO);
                        end
                    end
                end
`ifdef FBU_LOAD_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        if (8'(sum + in_data) == 8'd0) begin
                            state <= ST_RUN;
                            flg   <= flags_of(ST_RUN);
                        end else begin
                            state <= ST_ERR;
                            flg   <= flags_of(ST_ERR);
                            err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    flg   <= flags_of(ST_IDLE);
                end
            endcase
        end
    end

    // RAM port belongs to the CPU only in RUN; read data is zeroed in any cycle that is not RUN.
    always_comb begin
        ram_addr  = ld_addr;
        ram_we    = 1'b0;
        ram_wdata = {in_data[DATA_WIDTH-9:0], lo};
        if (state == ST_RUN) begin
            ram_addr  = cpu_mar;
            ram_we    = cpu_wr;
            ram_wdata = cpu_mdr_in;
        end else if (state == ST_HI) begin
            ram_we    = accept;
        end
    end

    assign ram_clr = rst || !(state == ST_RUN && !load_start);

    fbu_sp_ram #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .clr   (ram_clr),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (cpu_mdr_out)
    );

    assign cpu_rst  = flg.cpu_rst;
    assign busy     = flg.busy;
    assign done     = flg.done;
    assign in_ready = flg.in_ready;

endmodule

// File: tb/tb_fbu_prog_mem.sv
// Directed bench for fbu_prog_mem: loader protocol, CPU port timing, reset and count edge cases.
module tb_fbu_prog_mem;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [5:0] cpu_mar;
    logic       cpu_wr;
    logic [9:0] cpu_mdr_in;
    logic [9:0] cpu_mdr_out;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       load_err;

    int         checks;
    int         errors;
    logic [7:0] tsum;

`ifdef FBU_LOAD_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    fbu_prog_mem #(
        .ADDRESS_WIDTH (6),
        .DATA_WIDTH    (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .cpu_mar     (cpu_mar),
        .cpu_wr      (cpu_wr),
        .cpu_mdr_in  (cpu_mdr_in),
        .cpu_mdr_out (cpu_mdr_out),
        .cpu_rst     (cpu_rst),
        .busy        (busy),
        .done        (done),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tsum = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL handshake_timeout: in_ready=%b required 1 for byte %02h", in_ready, b);
        end
        tick();
        in_valid = 1'b0;
        tsum = 8'(tsum + b);
    endtask

    // Upper six bits of the high byte carry junk that the loader must drop.
    task automatic send_word(input logic [9:0] w, input int gap);
        send_byte(w[7:0], gap);
        send_byte({6'b101101, w[9:8]}, gap);
    endtask

    task automatic finish_load();
        logic [7:0] t;
        t = 8'(8'd0 - tsum);
        if (CSUM_ON) send_byte(t, 0);
    endtask

    task automatic cpu_read(input logic [5:0] a, output logic [9:0] d);
        cpu_mar = a;
        tick();
        d = cpu_mdr_out;
    endtask

    function automatic logic [9:0] pat(input int i, input int s);
        return 10'((i * 37 + s * 113 + 5) & 1023);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({cpu_rst, busy, done, in_ready, load_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: {cpu_rst,busy,done,in_ready,load_err}=%b required 10000",
                     {cpu_rst, busy, done, in_ready, load_err});
        end
        checks++;
        if (cpu_mdr_out !== 10'h000) begin
            errors++;
            $display("FAIL reset_mdr: cpu_mdr_out=%03h required 000", cpu_mdr_out);
        end
    endtask

    task automatic basic_image(input string tag);
        logic [9:0] d;
        start_load();
        send_byte(8'h03, 0);
        send_byte(8'h05, 0); send_byte(8'h00, 0);
        send_byte(8'h2A, 0); send_byte(8'h01, 0);
        send_byte(8'hFF, 0); send_byte(8'h03, 0);
        checks++;
        if (done !== !CSUM_ON || cpu_rst !== CSUM_ON) begin
            errors++;
            $display("FAIL %s_done_timing: done=%b cpu_rst=%b required %b %b",
                     tag, done, cpu_rst, !CSUM_ON, CSUM_ON);
        end
        finish_load();
        checks++;
        if ({done, cpu_rst, busy, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_run_flags: {done,cpu_rst,busy,in_ready}=%b required 1000",
                     tag, {done, cpu_rst, busy, in_ready});
        end
        cpu_read(6'd0, d);
        checks++;
        if (d !== 10'h005) begin errors++; $display("FAIL %s_mem0: got %03h required 005", tag, d); end
        cpu_read(6'd1, d);
        checks++;
        if (d !== 10'h12A) begin errors++; $display("FAIL %s_mem1: got %03h required 12A", tag, d); end
        cpu_read(6'd2, d);
        checks++;
        if (d !== 10'h3FF) begin errors++; $display("FAIL %s_mem2: got %03h required 3FF", tag, d); end
    endtask

    task automatic test_basic_load();
        start_load();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL count_state: busy=%b in_ready=%b required 1 1", busy, in_ready);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        basic_image("basic");
    endtask

    task automatic test_read_first();
        cpu_mar    = 6'd1;
        cpu_wr     = 1'b1;
        cpu_mdr_in = 10'h055;
        tick();
        cpu_wr = 1'b0;
        checks++;
        if (cpu_mdr_out !== 10'h12A) begin
            errors++;
            $display("FAIL read_first_old: cpu_mdr_out=%03h required 12A", cpu_mdr_out);
        end
        tick();
        checks++;
        if (cpu_mdr_out !== 10'h055) begin
            errors++;
            $display("FAIL read_first_new: cpu_mdr_out=%03h required 055", cpu_mdr_out);
        end
    endtask

    task automatic test_full_count(input logic [7:0] cnt, input int seed);
        logic [9:0] d;
        int         bad;
        start_load();
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL restart_flags_%0d: done=%b cpu_rst=%b required 0 1", cnt, done, cpu_rst);
        end
        send_byte(cnt, 0);
        for (int i = 0; i < 63; i++) send_word(pat(i, seed), 0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL full_early_end_%0d: busy=%b done=%b required 1 0", cnt, busy, done);
        end
        send_word(pat(63, seed), 0);
        finish_load();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_end_%0d: done=%b busy=%b required 1 0", cnt, done, busy);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            cpu_read(6'(i), d);
            if (d !== pat(i, seed)) begin
                if (bad == 0) $display("FAIL full_mem_%0d: addr %0d got %03h required %03h",
                                       cnt, i, d, pat(i, seed));
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    task automatic test_gaps();
        logic [9:0] img [4];
        logic [9:0] d;
        img[0] = 10'h1C3; img[1] = 10'h2F0; img[2] = 10'h00F; img[3] = 10'h3A5;
        start_load();
        send_byte(8'h04, int'($urandom_range(0, 3)));
        send_word(img[0], int'($urandom_range(0, 3)));
        send_byte(img[1][7:0], int'($urandom_range(1, 3)));
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midload_start: busy=%b done=%b required 1 0", busy, done);
        end
        send_byte({6'b101101, img[1][9:8]}, int'($urandom_range(0, 3)));
        send_word(img[2], int'($urandom_range(0, 3)));
        send_word(img[3], int'($urandom_range(0, 3)));
        finish_load();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL gaps_done: done=%b required 1", done);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(6'(i), d);
            checks++;
            if (d !== img[i]) begin
                errors++;
                $display("FAIL gaps_mem%0d: got %03h required %03h", i, d, img[i]);
            end
        end
    endtask

    task automatic test_rst_midload();
        start_load();
        send_byte(8'h02, 0);
        send_byte(8'h77, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cpu_rst, in_ready, busy, done, cpu_mdr_out} !== {4'b1000, 10'h000}) begin
            errors++;
            $display("FAIL rst_midload: cpu_rst=%b in_ready=%b busy=%b done=%b mdr=%03h required 1 0 0 0 000",
                     cpu_rst, in_ready, busy, done, cpu_mdr_out);
        end
        basic_image("after_rst");
    endtask

`ifdef FBU_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        logic [9:0] d;
        start_load();
        send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'hEF, 0);
        checks++;
        if (done !== 1'b1 || load_err !== 1'b0 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL csum_good: done=%b load_err=%b cpu_rst=%b required 1 0 0", done, load_err, cpu_rst);
        end
        cpu_read(6'd0, d);
        checks++;
        if (d !== 10'h010) begin errors++; $display("FAIL csum_mem0: got %03h required 010", d); end
        start_load();
        send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        repeat (3) tick();
        checks++;
        if (load_err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL csum_bad: load_err=%b cpu_rst=%b done=%b busy=%b required 1 1 0 0",
                     load_err, cpu_rst, done, busy);
        end
        start_load();
        checks++;
        if (load_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL csum_clear: load_err=%b busy=%b required 0 1", load_err, busy);
        end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        tsum       = 8'd0;
        rst        = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        cpu_mar    = 6'd0;
        cpu_wr     = 1'b0;
        cpu_mdr_in = 10'd0;
        test_reset();
        test_basic_load();
        test_read_first();
        test_full_count(8'h00, 1);
        test_full_count(8'd200, 2);
        test_gaps();
        test_rst_midload();
`ifdef FBU_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
